// File: rtl/ab_pair_assembler.sv
// ab_pair_assembler: rebuilds {a,b} byte pairs from a valid/ready/last byte stream and
// buffers completed records in a small first-word-fall-through FIFO.
// A frame ending on an a byte yields {a, PAD_BYTE} flagged as odd.
// Optional build macro AB_PAIR_ASSEMBLER_XSCRUB_EN: accepted bytes are forced to 2-state
// before storage and x_seen latches any X/Z seen on an accepted s_data.
module ab_pair_assembler #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_W    = 16,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [15:0]      m_data,
    output logic             m_odd,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] pair_cnt,
    output logic             x_seen
);

    // Pointer width never drops below one bit so DEPTH=1 still elaborates.
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_FW = $clog2(DEPTH + 1);

    localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(DEPTH);
    localparam logic [CNT_FW-1:0] CNT_ONE  = CNT_FW'(1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  PAIR_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        StWaitA,
        StWaitB
    } state_e;

    // Assembler state
    state_e            state_q;
    logic [7:0]        held_a_q;

    // FIFO storage: entry = {odd, a, b}
    logic [16:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_FW-1:0] count_q;
    logic [CNT_W-1:0]  pair_cnt_q;

    logic [7:0]        byte_in;
    logic              accept;
    logic              push;
    logic              pop;
    logic [16:0]       push_entry;
    logic [16:0]       head_entry;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

`ifdef AB_PAIR_ASSEMBLER_XSCRUB_EN
    bit   [7:0] byte_2s;
    logic       byte_has_x;
    logic       x_seen_q;

    // Assigning to a 2-state variable turns any X/Z bit into 0.
    assign byte_2s    = s_data;
    assign byte_in    = byte_2s;
    // Reduction XOR goes X if any input bit is X or Z.
    assign byte_has_x = ((^s_data) === 1'bx);
    assign x_seen     = x_seen_q;

    // Sticky record of unknown bits on accepted bytes, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_seen_q <= 1'b0;
        end else if (accept && byte_has_x) begin
            x_seen_q <= 1'b1;
        end
    end
`else
    assign byte_in = s_data;
    assign x_seen  = 1'b0;
`endif

    // Backpressure depends only on registered occupancy, never on m_ready.
    assign s_ready = !rst && (count_q != FULL_CNT);
    assign accept  = s_valid && s_ready;

    assign m_valid = (count_q != '0);
    assign pop     = m_valid && m_ready;

    // A record completes on a b byte, or on an a byte that closes its frame.
    assign push    = accept && ((state_q == StWaitB) || s_last);

    // Select the record written to the FIFO on a completing accept.
    always_comb begin
        push_entry = '0;
        if (state_q == StWaitB) begin
            push_entry = {1'b0, held_a_q, byte_in};
        end else begin
            push_entry = {1'b1, byte_in, PAD_BYTE};
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign m_data     = head_entry[15:0];
    assign m_odd      = head_entry[16];
    assign pair_cnt   = pair_cnt_q;

    // Pairing FSM: holds the a byte until its b byte (or end of frame) arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StWaitA;
            held_a_q <= 8'h00;
        end else if (accept) begin
            unique case (state_q)
                StWaitA: begin
                    if (!s_last) begin
                        held_a_q <= byte_in;
                        state_q  <= StWaitB;
                    end
                end
                StWaitB: begin
                    state_q <= StWaitA;
                end
                default: begin
                    state_q <= StWaitA;
                end
            endcase
        end
    end

    // FIFO storage and pointers; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Popped-record counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt_q <= '0;
        end else if (pop) begin
            pair_cnt_q <= pair_cnt_q + PAIR_ONE;
        end
    end

    // Occupancy must never exceed DEPTH nor underflow.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == FULL_CNT)));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop && (count_q == '0)));

endmodule

// File: tb/tb_ab_pair_assembler.sv
// Self-checking bench for ab_pair_assembler. Two instances share one stimulus stream:
// the main one (DEPTH=2, CNT_W=16, PAD_BYTE=00) and a second (CNT_W=2, PAD_BYTE=FF)
// used for padding-value and counter-wrap checks. A scoreboard queue holds the
// expected records, filled when a completing byte is accepted, drained on each pop.
module tb_ab_pair_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        m_ready;

    logic        s_ready;
    logic [15:0] m_data;
    logic        m_odd;
    logic        m_valid;
    logic [15:0] pair_cnt;
    logic        x_seen;

    logic        s_ready2;
    logic [15:0] m_data2;
    logic        m_odd2;
    logic        m_valid2;
    logic [1:0]  pair_cnt2;
    logic        x_seen2;

    int errors = 0;
    int checks = 0;

    logic [16:0] exp_q[$];
    logic [15:0] exp2_q[$];
    logic [16:0] mon_e;
    logic [15:0] mon_e2;

    logic        have_a;
    logic [7:0]  model_a;

    always #5 clk = ~clk;

    ab_pair_assembler #(
        .DEPTH   (2),
        .CNT_W   (16),
        .PAD_BYTE(8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_odd   (m_odd),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .pair_cnt(pair_cnt),
        .x_seen  (x_seen)
    );

    ab_pair_assembler #(
        .DEPTH   (2),
        .CNT_W   (2),
        .PAD_BYTE(8'hFF)
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready2),
        .m_data  (m_data2),
        .m_odd   (m_odd2),
        .m_valid (m_valid2),
        .m_ready (m_ready),
        .pair_cnt(pair_cnt2),
        .x_seen  (x_seen2)
    );

    // Scoreboard: a record leaves the FIFO at the next posedge whenever valid && ready.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got data=%h odd=%b, expected no record", m_data, m_odd);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_e2 = exp2_q.pop_front();
                if ({m_odd, m_data} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_record: got odd=%b data=%h, expected odd=%b data=%h",
                             m_odd, m_data, mon_e[16], mon_e[15:0]);
                end
                checks++;
                if (m_data2 !== mon_e2 || m_odd2 !== mon_e[16] || m_valid2 !== 1'b1) begin
                    errors++;
                    $display("FAIL sb_record_pad_ff: got v=%b odd=%b data=%h, expected v=1 odd=%b data=%h",
                             m_valid2, m_odd2, m_data2, mon_e[16], mon_e2);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        exp2_q.delete();
        have_a  = 1'b0;
        model_a = 8'h00;
        #1;
        rst = 1'b0;
    endtask

    // Offer one byte until accepted; callers enter shortly after a posedge.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int         waited;
        logic [7:0] clean;
`ifdef AB_PAIR_ASSEMBLER_XSCRUB_EN
        bit   [7:0] scrubbed;
`endif
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %h not accepted, s_ready=%b, required 1", d, s_ready);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        clean   = d;
`ifdef AB_PAIR_ASSEMBLER_XSCRUB_EN
        scrubbed = d;
        clean    = scrubbed;
`endif
        if (have_a) begin
            exp_q.push_back({1'b0, model_a, clean});
            exp2_q.push_back({model_a, clean});
            have_a = 1'b0;
        end else if (last) begin
            exp_q.push_back({1'b1, clean, 8'h00});
            exp2_q.push_back({clean, 8'hFF});
        end else begin
            have_a  = 1'b1;
            model_a = clean;
        end
    endtask

    task automatic drain();
        int waited;
        m_ready = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (m_valid !== 1'b0 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: m_valid=%b, required 0", m_valid);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_missing: %0d records never popped, required 0", exp_q.size());
        end
        sync();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_s_ready: got %b, required 0", s_ready);
        end
        checks++;
        if ({m_valid, m_odd, m_data} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b odd=%b data=%h, required all 0",
                     m_valid, m_odd, m_data);
        end
        checks++;
        if (pair_cnt !== 16'd0 || pair_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_pair_cnt: got %0d/%0d, required 0/0", pair_cnt, pair_cnt2);
        end
        checks++;
        if (x_seen !== 1'b0 || x_seen2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_x_seen: got %b/%b, required 0/0", x_seen, x_seen2);
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp2_q.delete();
        have_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_valid, m_odd, m_data} !== 18'h0 || pair_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_outputs: got v=%b odd=%b data=%h cnt=%0d, required all 0",
                     m_valid, m_odd, m_data, pair_cnt);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_s_ready: got %b, required 1", s_ready);
        end
        sync();
    endtask

    task automatic test_basic_pair();
        do_reset();
        m_ready = 1'b1;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h0102 || m_odd !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: got v=%b data=%h odd=%b, required v=1 data=0102 odd=0",
                     m_valid, m_data, m_odd);
        end
        sync();
        drain();
        @(negedge clk);
        checks++;
        if (pair_cnt !== 16'd1) begin
            errors++;
            $display("FAIL basic_pair_cnt: got %0d, required 1", pair_cnt);
        end
        sync();
    endtask

    task automatic test_odd_pad();
        do_reset();
        m_ready = 1'b1;
        send_byte(8'h03, 1'b1);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h0300 || m_odd !== 1'b1) begin
            errors++;
            $display("FAIL pad_00: got v=%b data=%h odd=%b, required v=1 data=0300 odd=1",
                     m_valid, m_data, m_odd);
        end
        checks++;
        if (m_data2 !== 16'h03FF || m_odd2 !== 1'b1) begin
            errors++;
            $display("FAIL pad_ff: got data=%h odd=%b, required data=03FF odd=1", m_data2, m_odd2);
        end
        sync();
        drain();
        @(negedge clk);
        checks++;
        if (x_seen !== 1'b0) begin
            errors++;
            $display("FAIL x_seen_clean: got %b, required 0", x_seen);
        end
        sync();
    endtask

    task automatic test_backpressure();
        do_reset();
        m_ready = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h14, 1'b0);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_flags: got s_ready=%b m_valid=%b, required 0/1", s_ready, m_valid);
        end
        sync();
        s_data  = 8'h15;
        s_last  = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || m_data !== 16'h1112 || m_odd !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got s_ready=%b data=%h odd=%b, required 0/1112/0",
                         i, s_ready, m_data, m_odd);
            end
            sync();
        end
        m_ready = 1'b1;
        send_byte(8'h15, 1'b0);
        send_byte(8'h16, 1'b1);
        drain();
        @(negedge clk);
        checks++;
        if (pair_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stall_pair_cnt: got %0d, required 3", pair_cnt);
        end
        sync();
    endtask

    task automatic test_push_pop_same_cycle();
        do_reset();
        m_ready = 1'b0;
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b1);
        send_byte(8'hA1, 1'b0);
        m_ready = 1'b1;
        send_byte(8'hA2, 1'b1);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'hA1A2 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_next: got v=%b data=%h s_ready=%b, required 1/A1A2/1",
                     m_valid, m_data, s_ready);
        end
        sync();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || pair_cnt !== 16'd2) begin
            errors++;
            $display("FAIL same_cycle_empty: got v=%b cnt=%0d, required 0/2", m_valid, pair_cnt);
        end
        sync();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready = 1'b0;
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b1);
        send_byte(8'hAA, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        exp2_q.delete();
        have_a = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_s_ready: got %b, required 0", s_ready);
        end
        sync();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || pair_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_flush: got v=%b cnt=%0d, required 0/0", m_valid, pair_cnt);
        end
        sync();
        m_ready = 1'b1;
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        @(negedge clk);
        checks++;
        if (m_data !== 16'h5566) begin
            errors++;
            $display("FAIL mid_reset_record: got %h, required 5566", m_data);
        end
        sync();
        drain();
        @(negedge clk);
        checks++;
        if (pair_cnt !== 16'd1) begin
            errors++;
            $display("FAIL mid_reset_pair_cnt: got %0d, required 1", pair_cnt);
        end
        sync();
    endtask

    task automatic test_cnt_wrap();
        logic [7:0] b;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b = 8'h40 + 8'(2 * i);
            send_byte(b, 1'b0);
            send_byte(b + 8'h01, 1'b1);
        end
        drain();
        @(negedge clk);
        checks++;
        if (pair_cnt2 !== 2'd1) begin
            errors++;
            $display("FAIL wrap_pair_cnt2: got %0d, required 1", pair_cnt2);
        end
        checks++;
        if (pair_cnt !== 16'd5) begin
            errors++;
            $display("FAIL wrap_pair_cnt16: got %0d, required 5", pair_cnt);
        end
        sync();
    endtask

`ifdef AB_PAIR_ASSEMBLER_XSCRUB_EN
    task automatic test_xscrub();
        do_reset();
        m_ready = 1'b1;
        send_byte(8'bxxxx_0101, 1'b0);
        send_byte(8'h07, 1'b1);
        @(negedge clk);
        checks++;
        if (m_data !== 16'h0507) begin
            errors++;
            $display("FAIL xscrub_data: got %h, required 0507", m_data);
        end
        checks++;
        if (x_seen !== 1'b1) begin
            errors++;
            $display("FAIL xscrub_x_seen: got %b, required 1", x_seen);
        end
        sync();
        drain();
        @(negedge clk);
        checks++;
        if (x_seen !== 1'b1) begin
            errors++;
            $display("FAIL xscrub_sticky: got %b, required 1", x_seen);
        end
        sync();
        do_reset();
        @(negedge clk);
        checks++;
        if (x_seen !== 1'b0) begin
            errors++;
            $display("FAIL xscrub_cleared: got %b, required 0", x_seen);
        end
        sync();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        have_a  = 1'b0;
        model_a = 8'h00;
        test_reset();
        test_basic_pair();
        test_odd_pad();
        test_backpressure();
        test_push_pop_same_cycle();
        test_reset_mid();
        test_cnt_wrap();
`ifdef AB_PAIR_ASSEMBLER_XSCRUB_EN
        test_xscrub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ab_pair_assembler.md
Name: ab_pair_assembler

Overview:
- Receive-side counterpart of the ab struct splitter. That splitter breaks an l2_pkg::ab record into its a and b bytes.
- This block accepts a byte stream with valid/ready/last and rebuilds ab records: the first byte becomes a, the second becomes b.
- Completed records are buffered in a small first-word-fall-through FIFO and presented on a valid/ready output.
- Sits between a byte-wide link interface and any consumer that takes ab records.

Parameters:
- DEPTH, 2, number of ab records the output FIFO holds (legal range 1..16).
- CNT_W, 16, width of the popped-record counter.
- PAD_BYTE, 8'h00, value placed in b when a frame ends on an a byte.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- s_data  input  8  input byte.
- s_valid  input  1  s_data is valid.
- s_last  input  1  the current byte is the last byte of its frame.
- s_ready  output  1  block can accept a byte.
- m_data  output  16  ab record, packed as {a,b}: a in [15:8], b in [7:0].
- m_odd  output  1  record was padded (frame had an odd byte count).
- m_valid  output  1  m_data and m_odd are valid.
- m_ready  input  1  consumer accepts the record.
- pair_cnt  output  CNT_W  count of records popped, modulo 2^CNT_W.
- x_seen  output  1  sticky flag: an X/Z bit was seen on s_data (feature only).

Behaviour:
- Reset values while rst=1 and on the first cycle after it:
  - Outputs: m_valid=0, m_data=0, m_odd=0, pair_cnt=0, x_seen=0.
  - Internal: FIFO empty, state WAIT_A, held a byte = 0.
- s_ready is 0 while rst=1. Otherwise s_ready = (count != DEPTH). It is combinational from registered count only and has no path from m_ready.
- A byte is accepted when s_valid && s_ready. While s_valid=1 and s_ready=0, upstream holds s_data and s_last stable.
- State WAIT_A, on accept:
  - s_last=0: store the byte as a, go to WAIT_B.
  - s_last=1: push {byte, PAD_BYTE} with odd=1, stay in WAIT_A.
- State WAIT_B, on accept: push {held a, byte} with odd=0, go to WAIT_A. s_last has no effect on pairing in this state.
- No accept: state and held a are unchanged.
- FIFO:
  - First-word-fall-through: m_valid = (count != 0); m_data and m_odd show the head entry.
  - Pop happens when m_valid && m_ready.
  - Push and pop in the same cycle leave count unchanged. Data is never lost or duplicated.
  - A push while full cannot occur, because s_ready is 0 when full.
  - m_data and m_odd stay stable while m_valid=1 and m_ready=0.
- Latency: the byte that completes a record, accepted in cycle N, appears as m_valid=1 in cycle N+1 when the FIFO was empty.
- pair_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: any held a byte and all FIFO contents are discarded, and state returns to WAIT_A.

Optional Feature:
- Macro: AB_PAIR_ASSEMBLER_XSCRUB_EN.
- Defined:
  - Every accepted byte is cast to a 2-state type before storage, so X/Z bits become 0.
  - x_seen is set to 1 when any accepted s_data bit is X or Z (detected with ===). It stays 1 until rst.
- Not defined:
  - Bytes are stored unmodified and X propagates to m_data.
  - x_seen is tied to 0.

Test Plan:
- Reset, then send 0x01, 0x02 (s_last on 0x02) with m_ready=1. Expect m_valid=1 one cycle after 0x02 is accepted, m_data=16'h0102, m_odd=0, and pair_cnt=1 after the pop.
- Send a single byte 0x03 with s_last=1. Expect m_data=16'h0300, m_odd=1. With PAD_BYTE=8'hFF, expect 16'h03FF.
- DEPTH=2, m_ready=0, send 0x11..0x16. Expect s_ready=0 after 0x14 is accepted and 0x15 stalled. Then set m_ready=1 and expect 0x1112, 0x1314, 0x1516 in order with no gaps or repeats, and pair_cnt=3.
- count=1, push and pop in the same cycle. Expect count to stay 1 and the next record to appear on the following cycle with no loss.
- Accept 0xAA, pulse rst for one cycle, then send 0x55, 0x66. Expect only m_data=16'h5566 and pair_cnt=1; no record containing 0xAA.
- CNT_W=2, pop 5 records. Expect pair_cnt=1.
- With AB_PAIR_ASSEMBLER_XSCRUB_EN defined, send 8'bxxxx_0101 then 0x07. Expect m_data=16'h0507 and x_seen=1 until reset.
